// File: rtl/xy_seq_pkg.sv
// Shared types and constants for the XY vector sequencer and its point RAM.
package xy_seq_pkg;

    localparam int DEFAULT_DEPTH   = 32;
    localparam int DEFAULT_DWELL_W = 8;

    // Point-list entry layout: {blank[15], y[14:8], x[7:0]}
    localparam int ENTRY_W   = 16;
    localparam int X_LSB     = 0;
    localparam int X_W       = 8;
    localparam int Y_LSB     = 8;
    localparam int Y_W       = 7;
    localparam int BLANK_BIT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic           blank;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } point_t;

    function automatic point_t to_point(input logic [ENTRY_W-1:0] e);
        point_t p;
        p.x     = e[X_LSB +: X_W];
        p.y     = e[Y_LSB +: Y_W];
        p.blank = e[BLANK_BIT];
        return p;
    endfunction

endpackage

// File: rtl/xy_point_ram.sv
// Point-list storage: DEPTH x 16, one write port, one read port.
// The read is synchronous from the consumer's side: rd_addr is presented
// during a cycle and the entry is captured by the sequencer's output
// registers on the closing edge. A write on that same edge is not yet
// visible, so a same-edge read returns the old entry.
module xy_point_ram
    import xy_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Store one entry per strobed edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xy_vector_sequencer.sv
// Plays a stored list of XY points out to the BNC outputs, holding each
// point for a programmable dwell, with optional frame looping.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | outputs blanked, x/y hold, waiting for a valid start
// PRIME | one cycle: read of index 0 presented to the RAM
// RUN   | a point is on the outputs; dwell counter runs down to 0
module xy_vector_sequencer
    import xy_seq_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH):0]   list_len,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic [X_W-1:0]           BNC_x,
    output logic [Y_W-1:0]           BNC_y,
    output logic                     BNC_blank,
    output logic                     BNC_trig,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    seq_state_t         state;
    logic [AW:0]        len_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [AW-1:0]      idx_q;
    logic [DWELL_W-1:0] cnt_q;

    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] rd_data;
    point_t             rd_pt;

    logic               len_ok;
    logic [DWELL_W-1:0] dwell_m1;
    logic               last_cycle;
    logic               last_point;
    logic [AW-1:0]      idx_nxt;
    logic               load_pt;
    logic               end_run;
    logic               new_fd;

    xy_point_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_pt      = to_point(rd_data);
    assign len_ok     = (list_len != '0) && (list_len <= DEPTH_L);
    // A dwell of 0 behaves as 1: the counter starts already at terminal count.
    assign dwell_m1   = (dwell_q == '0) ? '0 : dwell_q - CNT_ONE;
    assign last_cycle = (cnt_q == '0);
    assign last_point = ({1'b0, idx_q} == len_q - 1'b1);
    assign idx_nxt    = last_point ? '0 : idx_q + 1'b1;
    // The next entry is addressed throughout RUN and captured only on the
    // edge that closes a point's last dwell cycle, so points abut with no gap.
    assign rd_addr    = (state == RUN) ? idx_nxt : '0;
    assign load_pt    = !stop && ((state == PRIME) ||
                        ((state == RUN) && last_cycle && (!last_point || loop)));
    assign end_run    = (state != IDLE) && !load_pt &&
                        (stop || (state == RUN && last_cycle));
    // Point being loaded is the frame's last and lasts only one cycle.
    assign new_fd     = (dwell_m1 == '0) && ({1'b0, rd_addr} == len_q - 1'b1);
    assign busy       = (state != IDLE);

    // Sequencer FSM with index, dwell counter and registered BNC outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            dwell_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            BNC_x      <= '0;
            BNC_y      <= '0;
            BNC_blank  <= 1'b1;
            BNC_trig   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_pt) begin
                state      <= RUN;
                idx_q      <= rd_addr;
                cnt_q      <= dwell_m1;
                BNC_x      <= rd_pt.x;
                BNC_y      <= rd_pt.y;
                BNC_blank  <= rd_pt.blank;
                BNC_trig   <= (rd_addr == '0);
                frame_done <= new_fd;
            end else if (end_run) begin
                state     <= IDLE;
                idx_q     <= '0;
                cnt_q     <= '0;
                BNC_blank <= 1'b1;
                BNC_trig  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        BNC_blank <= 1'b1;
                        BNC_trig  <= 1'b0;
                        if (start && !stop && len_ok) begin
                            state   <= PRIME;
                            len_q   <= list_len;
                            dwell_q <= dwell;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    RUN: begin
                        cnt_q      <= cnt_q - CNT_ONE;
                        frame_done <= last_point && (cnt_q == CNT_ONE);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xy_vector_sequencer.sv
module tb_xy_vector_sequencer;

    localparam int DEPTH   = 32;
    localparam int DWELL_W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [15:0]  wr_data;
    logic [5:0]   list_len;
    logic [DWELL_W-1:0] dwell;
    logic         start, stop, loop;
    logic [7:0]   BNC_x;
    logic [6:0]   BNC_y;
    logic         BNC_blank, BNC_trig, busy, frame_done;

    xy_vector_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .list_len   (list_len),
        .dwell      (dwell),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .BNC_x      (BNC_x),
        .BNC_y      (BNC_y),
        .BNC_blank  (BNC_blank),
        .BNC_trig   (BNC_trig),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       fd;
        logic       trig;
        logic       blank;
        logic [6:0] y;
        logic [7:0] x;
    } obs_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem_model [DEPTH];
    obs_t        exp_q [$];
    logic [7:0]  held_x;
    logic [6:0]  held_y;

    function automatic obs_t sample();
        return {busy, frame_done, BNC_trig, BNC_blank, BNC_y, BNC_x};
    endfunction

    function automatic obs_t idle_obs(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, 1'b0, 1'b0, 1'b1, y, x};
    endfunction

    // Expected per-cycle view starting with the cycle after the start edge:
    // one priming cycle, then every point of every frame for max(dwell,1)
    // cycles, then two idle cycles.
    function automatic void build_expect(input int len, input int dw, input int frames);
        int   d;
        obs_t e;
        d = (dw == 0) ? 1 : dw;
        exp_q.delete();
        e = {1'b1, 1'b0, 1'b0, 1'b1, held_y, held_x};
        exp_q.push_back(e);
        for (int f = 0; f < frames; f++)
            for (int i = 0; i < len; i++)
                for (int c = 0; c < d; c++) begin
                    e.busy  = 1'b1;
                    e.x     = mem_model[i][7:0];
                    e.y     = mem_model[i][14:8];
                    e.blank = mem_model[i][15];
                    e.trig  = (i == 0);
                    e.fd    = (i == len - 1) && (c == d - 1);
                    exp_q.push_back(e);
                end
        e.busy  = 1'b0;
        e.fd    = 1'b0;
        e.trig  = 1'b0;
        e.blank = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pt(input int addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        mem_model[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic kick(input int len, input int dw);
        list_len = 6'(len);
        dwell    = DWELL_W'(dw);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic write_base_list();
        write_pt(0, {1'b0, 7'd5,  8'd10});
        write_pt(1, {1'b0, 7'd15, 8'd20});
        write_pt(2, {1'b0, 7'd25, 8'd30});
        write_pt(3, {1'b0, 7'd35, 8'd40});
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        list_len = '0; dwell = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        #3;
        o = sample();
        total++;
        if (o !== idle_obs(8'd0, 7'd0)) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", o, idle_obs(8'd0, 7'd0));
        end
        repeat (3) tick();
        o = sample();
        total++;
        if (o !== idle_obs(8'd0, 7'd0)) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", o, idle_obs(8'd0, 7'd0));
        end
        reset = 1'b0;
        tick();
        o = sample();
        total++;
        if (o !== idle_obs(8'd0, 7'd0)) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", o, idle_obs(8'd0, 7'd0));
        end
        held_x = 8'd0;
        held_y = 7'd0;
    endtask

    task automatic test_single_frame();
        obs_t o;
        int   nfd = 0;
        write_base_list();
        loop = 1'b0;
        build_expect(4, 3, 1);
        kick(4, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL single_frame cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            if (o.fd) nfd++;
            tick();
        end
        total++;
        if (nfd != 1) begin
            bad++;
            $display("FAIL single_frame_fd_count: got %0d want 1", nfd);
        end
        held_x = exp_q[exp_q.size()-1].x;
        held_y = exp_q[exp_q.size()-1].y;
    endtask

    task automatic test_loop_frames();
        obs_t o;
        int   fd_at [$];
        loop = 1'b1;
        build_expect(4, 3, 3);
        kick(4, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 30) loop = 1'b0;
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL loop_frames cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            if (o.fd) fd_at.push_back(k);
            tick();
        end
        total++;
        if (fd_at.size() != 3) begin
            bad++;
            $display("FAIL loop_fd_count: got %0d want 3", fd_at.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (fd_at[i] - fd_at[i-1] != 12) begin
                    bad++;
                    $display("FAIL loop_fd_spacing %0d: got %0d want 12", i, fd_at[i] - fd_at[i-1]);
                end
            end
        end
        loop = 1'b0;
        held_x = exp_q[exp_q.size()-1].x;
        held_y = exp_q[exp_q.size()-1].y;
    endtask

    task automatic test_min_dwell();
        obs_t o;
        write_pt(0, {1'b0, 7'd127, 8'd255});
        loop = 1'b0;
        build_expect(1, 0, 1);
        kick(1, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL min_dwell cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            tick();
        end
        held_x = 8'd255;
        held_y = 7'd127;
    endtask

    task automatic test_stop();
        obs_t o;
        write_base_list();
        loop = 1'b0;
        build_expect(4, 3, 1);
        kick(4, 3);
        for (int k = 0; k <= 5; k++) begin
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL stop_run cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            if (k == 5) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            o = sample();
            total++;
            if (o !== idle_obs(8'd20, 7'd15)) begin
                bad++;
                $display("FAIL stop_idle cyc %0d: got %h want %h", k, o, idle_obs(8'd20, 7'd15));
            end
            tick();
        end
        list_len = 6'd4;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        o = sample();
        total++;
        if (o !== idle_obs(8'd20, 7'd15)) begin
            bad++;
            $display("FAIL stop_beats_start: got %h want %h", o, idle_obs(8'd20, 7'd15));
        end
        held_x = 8'd20;
        held_y = 7'd15;
    endtask

    task automatic test_overwrite();
        obs_t o;
        loop = 1'b0;
        mem_model[2] = {1'b0, 7'd25, 8'd99};
        build_expect(4, 3, 1);
        kick(4, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL overwrite cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            wr_en   = (k == 4);
            wr_addr = 5'd2;
            wr_data = {1'b0, 7'd25, 8'd99};
            tick();
        end
        wr_en = 1'b0;
        held_x = 8'd40;
        held_y = 7'd35;
        kick(0, 3);
        for (int k = 0; k < 2; k++) begin
            o = sample();
            total++;
            if (o !== idle_obs(held_x, held_y)) begin
                bad++;
                $display("FAIL len_zero cyc %0d: got %h want %h", k, o, idle_obs(held_x, held_y));
            end
            tick();
        end
        kick(33, 3);
        o = sample();
        total++;
        if (o !== idle_obs(held_x, held_y)) begin
            bad++;
            $display("FAIL len_over_depth: got %h want %h", o, idle_obs(held_x, held_y));
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        loop = 1'b0;
        kick(4, 3);
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        o = sample();
        total++;
        if (o !== idle_obs(8'd0, 7'd0)) begin
            bad++;
            $display("FAIL reset_mid_run: got %h want %h", o, idle_obs(8'd0, 7'd0));
        end
        #2;
        reset  = 1'b0;
        held_x = 8'd0;
        held_y = 7'd0;
        build_expect(4, 3, 1);
        kick(4, 3);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = sample();
            total++;
            if (o !== exp_q[k]) begin
                bad++;
                $display("FAIL restart_replay cyc %0d: got %h want %h", k, o, exp_q[k]);
            end
            tick();
        end
        held_x = exp_q[exp_q.size()-1].x;
        held_y = exp_q[exp_q.size()-1].y;
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 8; it++) begin
            int len  = int'($urandom_range(6, 1));
            int dw   = int'($urandom_range(4, 0));
            int fr   = int'($urandom_range(2, 1));
            int d    = (dw == 0) ? 1 : dw;
            int n    = fr * len * d;
            int spur = int'($urandom_range(n, 1));
            int drop = len * d + 1 + int'($urandom % (len * d));
            for (int i = 0; i < len; i++) write_pt(i, 16'($urandom));
            loop = (fr == 2);
            build_expect(len, dw, fr);
            kick(len, dw);
            for (int k = 0; k < exp_q.size(); k++) begin
                o = sample();
                total++;
                if (o !== exp_q[k]) begin
                    bad++;
                    $display("FAIL random it %0d cyc %0d: got %h want %h", it, k, o, exp_q[k]);
                end
                start = (k == spur);
                if (k == 1) begin
                    list_len = 6'($urandom);
                    dwell    = DWELL_W'($urandom);
                end
                if (fr == 2 && k == drop) loop = 1'b0;
                tick();
            end
            start  = 1'b0;
            loop   = 1'b0;
            held_x = exp_q[exp_q.size()-1].x;
            held_y = exp_q[exp_q.size()-1].y;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_loop_frames();
        test_min_dwell();
        test_stop();
        test_overwrite();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xy_vector_sequencer.md
XY_VECTOR_SEQUENCER -- requirements
Module: xy_vector_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, point-list entries (power of two, 2..256).
REQ-002 SHALL have parameter DWELL_W, default 8, dwell-counter width.
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: wr_en  input  1  point-list write strobe.
REQ-006 SHALL have port: wr_addr  input  log2(DEPTH)  write index.
REQ-007 SHALL have port: wr_data  input  16  entry {blank[15], y[14:8], x[7:0]}.
REQ-008 SHALL have port: list_len  input  log2(DEPTH)+1  point count, sampled at start.
REQ-009 SHALL have port: dwell  input  DWELL_W  cycles per point, sampled at start.
REQ-010 SHALL have ports: start, stop, loop  input  1 each  run-control pulse/pulse/level.
REQ-011 SHALL have ports: BNC_x output 8, BNC_y output 7, BNC_blank output 1, BNC_trig output 1, all registered.
REQ-012 SHALL have ports: busy output 1 (state != IDLE), frame_done output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, PRIME, RUN.
REQ-014 IDLE: start=1 with list_len in 1..DEPTH -> PRIME, latch len and dwell; list_len=0 or >DEPTH -> stay IDLE.
REQ-015 PRIME (exactly 1 cycle): issue synchronous read of index 0 -> RUN.
REQ-016 RUN entry: outputs take x, y, blank of current entry on the same edge; dwell counter loads latched dwell-1.
REQ-017 Each point SHALL be held exactly max(dwell,1) cycles; dwell=0 treated as 1.
REQ-018 Read of next index SHALL be issued in last dwell cycle of current point so next point appears with zero gap.
REQ-019 Index SHALL advance 0..len-1; after len-1: loop=1 -> wrap to 0, no gap; loop=0 -> IDLE.
REQ-020 frame_done SHALL pulse in the last dwell cycle of index len-1, every frame.
REQ-021 BNC_trig SHALL be high for all cycles index 0 is displayed, low otherwise.
REQ-022 Point 0 SHALL appear on outputs 2 cycles after the edge sampling start.
REQ-023 start while busy SHALL be ignored; stop SHALL win over start in same cycle.
REQ-024 stop in PRIME/RUN -> IDLE next edge; BNC_x/BNC_y hold, BNC_blank=1, BNC_trig=0, no frame_done.
REQ-025 In IDLE, BNC_blank SHALL be 1, BNC_trig 0; BNC_x/BNC_y hold last value.
REQ-026 Writes SHALL be accepted in any state; a write to an index takes effect for any read issued on a later edge; same-edge read returns old data.
REQ-027 Changes to list_len, dwell while busy SHALL have no effect until next start.
REQ-028 loop deasserted mid-frame SHALL end playback after current frame's last point.

Reset
REQ-029 reset SHALL force IDLE, BNC_x=0, BNC_y=0, BNC_blank=1, BNC_trig=0, busy=0, frame_done=0, index=0, counter=0.
REQ-030 reset mid-RUN SHALL take effect asynchronously; point RAM contents are not cleared.
REQ-031 Deassertion SHALL be followed by IDLE behaviour; start accepted on first edge after release.

Structure
REQ-032 Package xy_seq_pkg SHALL hold state enum, entry field bit positions, default DEPTH/DWELL_W.
REQ-033 Point storage SHALL be sub-module xy_point_ram: one write port, one synchronous read port, DEPTH x 16.
REQ-034 FSM, index, dwell counter and output registers SHALL reside in xy_vector_sequencer.

Verification
REQ-035 Write 4 points (x=10,20,30,40; y=5,15,25,35), len=4, dwell=3, loop=0, start -> each point held 3 cycles, trig during point 0 only, frame_done once, busy low after 12 RUN cycles.
REQ-036 Same list, loop=1, run 3 frames -> sequence repeats with no gap, 3 frame_done pulses 12 cycles apart.
REQ-037 dwell=0, len=1 (x=255,y=127) -> one-cycle point, frame_done and trig high same cycle, IDLE next.
REQ-038 stop on 5th RUN cycle -> busy=0 next edge, BNC_blank=1, outputs hold x=20,y=15, no frame_done.
REQ-039 Overwrite index 2 with x=99 during point 1's first dwell cycle -> point 2 shows x=99; list_len=0 start -> stays IDLE.
REQ-040 reset asserted mid-RUN -> all outputs at reset values before next edge; restart replays unchanged RAM.
